// File: rtl/tube_scan_driver_if.sv
// CPU bridge port for the tube scan driver: register select, byte-enabled write, combinational read.
interface tube_scan_driver_if;
   logic        addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] WD;
   logic [31:0] RD;

   modport master (output addr, output we, output be, output WD, input RD);
   modport slave  (input addr, input we, input be, input WD, output RD);
endinterface

// File: rtl/tube_scan_driver.sv
// Eight-digit hex display driver for a multiplexed active-low 7-segment tube, with DATA/CTRL registers.
// Optional leading-zero suppression is built when TUBE_LZ_SUPPRESS_EN is defined.
module tube_scan_driver #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   tube_scan_driver_if.slave    bus,
   output logic [7:0]           digit_sel,
   output logic [7:0]           seg
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [31:0]      data_q, data_d;
   logic [31:0]      disp_q, disp_d;
   logic             blank_q, blank_d;
   logic [7:0]       dp_q, dp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       digit_sel_d, seg_d;
   logic [3:0]       nib;
   logic             lz_blank;

   // Segment pattern g..a for one hex nibble, active-low.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   assign bus.RD = reset ? 32'h0
                 : (bus.addr ? {16'h0, dp_q, 7'h0, blank_q} : data_q);

   // Register writes and scan sequencing; disp latches the pre-edge DATA at frame wrap.
   always_comb begin
      data_d  = data_q;
      blank_d = blank_q;
      dp_d    = dp_q;
      disp_d  = disp_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (bus.we) begin
         if (!bus.addr) begin
            for (int i = 0; i < 4; i++) begin
               if (bus.be[i]) data_d[8*i +: 8] = bus.WD[8*i +: 8];
            end
         end else begin
            if (bus.be[0]) blank_d = bus.WD[0];
            if (bus.be[1]) dp_d    = bus.WD[15:8];
         end
      end
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = idx_q + 3'd1;
         if (idx_q == 3'd7) disp_d = data_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign nib = disp_q[{idx_q, 2'b00} +: 4];

`ifdef TUBE_LZ_SUPPRESS_EN
   logic [31:0] upper;
   assign upper    = disp_q >> {idx_q, 2'b00};
   assign lz_blank = (idx_q != 3'd0) && (upper == 32'h0);
`else
   assign lz_blank = 1'b0;
`endif

   // Output decode for the current digit, registered below.
   always_comb begin
      digit_sel_d = 8'hFF;
      seg_d       = 8'hFF;
      if (!blank_q && !lz_blank) begin
         digit_sel_d = ~(8'd1 << idx_q);
         seg_d       = {~dp_q[idx_q], hex7(nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q    <= 32'h0;
         disp_q    <= 32'h0;
         blank_q   <= 1'b0;
         dp_q      <= 8'h0;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         digit_sel <= 8'hFF;
         seg       <= 8'hFF;
      end else begin
         data_q    <= data_d;
         disp_q    <= disp_d;
         blank_q   <= blank_d;
         dp_q      <= dp_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         digit_sel <= digit_sel_d;
         seg       <= seg_d;
      end
   end

endmodule

// File: doc/tube_scan_driver.md
# tube_scan_driver

- Memory-mapped output device on the system bridge; the write-side counterpart of the DIP-switch input device.
- Takes a 32-bit value written by the CPU and shows it as 8 hex digits on a time-multiplexed, active-low 7-segment display.
- Has a control register for blanking and decimal points.
- Scans digits with a programmable clock divider.
- Loads the displayed value only at frame boundaries, so a frame never mixes old and new digits.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit is driven. Legal range is ≥2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  1  register select: 0 = DATA, 1 = CTRL.
- `we`  in  1  write strobe from the bridge.
- `be`  in  4  byte enables for the write; `be[i]` covers `WD[8i+7:8i]`.
- `WD`  in  32  write data.
- `RD`  out  32  read data; combinational.
- `digit_sel`  out  8  digit enables, active-low; bit k drives digit k, and digit 0 is the least-significant nibble.
- `seg`  out  8  segments, active-low; `seg[6:0]` = g..a, `seg[7]` = dp.

## Operation

Registers:
- **DATA[31:0]**: shadow value. Reset value is 0.
- **CTRL**: implemented bits are `[0]` blank and `[15:8]` dp mask (bit 8+k lights the dp of digit k). All other bits read as 0. Reset value is 0.
- **disp[31:0]**: internal display copy. Reset value is 0.

Writes and reads:
- On a clock edge with `we`=1, each enabled byte of the `addr`-selected register takes the matching `WD` byte. Unimplemented CTRL bits ignore writes.
- `RD` = `reset` ? 0 : (`addr` ? CTRL : DATA). Reads show the shadow register, not `disp`.

Scan state:
- `cnt` runs 0..SCAN_DIV-1.
- When `cnt`=SCAN_DIV-1, `cnt` wraps to 0 and `idx` (3 bits) increments mod 8.
- On the edge where `idx` goes 7→0, `disp` <= DATA, using the pre-edge DATA value.
- A write on that same edge reaches `disp` only at the next frame boundary.

Output decode, for nibble n = `disp[4*idx+3:4*idx]`:
- `digit_sel` = ~(1<<idx); `seg[6:0]` = hex pattern of n; `seg[7]` = ~CTRL[8+idx].
- Hex patterns (`seg` with dp off): 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- If CTRL[0]=1: `digit_sel`=FF and `seg`=FF. The scan counters keep running, so unblanking resumes mid-frame with no phase reset.

## Timing

- `digit_sel` and `seg` are registered, one cycle behind (`idx`, `disp`, CTRL).
- Reset values: `digit_sel`=FF, `seg`=FF, `cnt`=0, `idx`=0. First lit output (digit 0) appears on the first edge after `reset` falls.
- Each digit is driven for exactly SCAN_DIV cycles. One frame is 8·SCAN_DIV cycles.
- Register writes take effect on the write edge (`RD` shows the new value the next cycle).
- A DATA write is displayed at the next frame boundary: latency 1..8·SCAN_DIV cycles, plus one for the output register.
- CTRL changes (blank, dp) affect outputs one cycle after the write edge, with no frame wait.
- `reset` asserted mid-frame: on the next edge, all state returns to reset values. A write with `reset`=1 is ignored.

## Configuration

- **`TUBE_LZ_SUPPRESS_EN`** defined: leading-zero suppression is enabled.
  - Digit k>0 is blanked (`digit_sel` bit high, `seg`=FF) when `disp[31:4k]`==0.
  - Digit 0 is always shown.
  - Evaluated on `disp`, so suppression changes only at frame boundaries.
- Undefined: all 8 digits are always shown, including leading zeros.

## Test plan

- **Reset and scan.** SCAN_DIV=4, release reset, no writes. Expect outputs FF during reset. Then `digit_sel` cycles FE, FD, …, 7F, each for 4 cycles. `seg`=C0 throughout.
- **Frame-boundary load.** Write DATA=0x1234ABCD with `be`=F mid-frame. Expect `RD`=0x1234ABCD next cycle. The current frame still shows 0s. From the next frame: digit0 `seg`=A1, digit1 C6, digit2 83, digit3 88, digit4 99, digit5 B0, digit6 A4, digit7 F9.
- **Byte enables and readback.** After the previous write, write DATA with `be`=0010 and `WD`=0xFFFF55FF. Expect `RD`=0x123455CD. Write CTRL=0xFFFF0301. Expect CTRL readback 0x00000301 and blanked outputs (FF/FF) one cycle later.
- **Decimal points.** Write CTRL=0x00000300. Expect digits 0 and 1 show `seg` with bit7=0 (e.g. CD → digit0 21, digit1 46). Other digits have bit7=1.
- **Leading zeros.** With `TUBE_LZ_SUPPRESS_EN`, write DATA=0x00000A00. Expect digits 3–7 dark, digit2=88, digits1/0=C0. With DATA=0, only digit0 is lit (C0). Without the macro, all digits are lit.
- **Reset mid-operation.** Pulse `reset` during digit 5 with DATA=0xFFFFFFFF. Expect the next edge gives outputs FF, `RD`=0, and DATA/`disp`=0. After release, the scan restarts at digit 0 showing C0.
